// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg -- shared definitions for the exception/interrupt sequencer.
//   * CP0 register indices written by the sequencer (Status, Cause, EPC)
//   * 3-bit FSM state encoding
//   * Status / Cause field positions and word-builder helpers
// ---------------------------------------------------------------------------
package exc_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status register bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    // Cause.ExcCode occupies [6:2]
    localparam int CAUSE_EXC_LSB = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_EPC   = 3'd1,
        S_W_CAUSE = 3'd2,
        S_W_STAT  = 3'd3,
        S_E_STAT  = 3'd4,
        S_REDIR   = 3'd5
    } exc_state_e;

    // Status word with only EXL/IE populated; all other bits written as 0.
    function automatic logic [31:0] status_word(input logic exl, input logic ie);
        logic [31:0] w;
        w             = '0;
        w[STATUS_EXL] = exl;
        w[STATUS_IE]  = ie;
        return w;
    endfunction

    // Cause word with ExcCode in [6:2]; all other bits written as 0.
    function automatic logic [31:0] cause_word(input logic [4:0] code);
        logic [31:0] w;
        w                                  = '0;
        w[CAUSE_EXC_LSB+4:CAUSE_EXC_LSB]   = code;
        return w;
    endfunction

endpackage

// File: rtl/exc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// exc_seq_ctrl -- exception / interrupt / ERET sequencer feeding CP0.
//
// On a trap it writes EPC, Cause and Status through CP0's single write port
// on three consecutive cycles, then issues a one-cycle redirect to the
// handler. On ERET it writes Status (EXL=0, IE=1) and redirects to the
// saved EPC. The pipeline is stalled (busy) in every non-IDLE state.
//
// Ports
//   CLK, RST_n          clock, asynchronous active-low reset
//   exc_req/exc_code    sync exception request (held until exc_ack) + ExcCode
//   exc_pc              restart PC captured into EPC
//   int_req             level interrupt request
//   eret                ERET retiring (1-cycle pulse)
//   exc_ack             1-cycle pulse the cycle after a trap/ERET is accepted
//   busy                pipeline stall
//   redirect/redirect_pc  1-cycle PC redirect strobe + target
//   CP0Wr/W_Reg/W_data  CP0 write port (CP0 samples on negedge)
//
// Configuration
//   EXC_INT_MASK_EN  when defined, int_req is accepted only while the
//                    internal IE copy is set (cleared at W_STAT of entry,
//                    set again at E_STAT of ERET). When undefined, int_req
//                    is accepted in any IDLE cycle.
//
// All outputs come straight from flops: the next-state logic computes the
// output values for the state being entered, so nothing combinational sits
// between inputs and outputs.
// ---------------------------------------------------------------------------
module exc_seq_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter logic [4:0]  INT_CODE     = 5'd0
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        int_req,
    input  logic        eret,
    output logic        exc_ack,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        CP0Wr,
    output logic [4:0]  W_Reg,
    output logic [31:0] W_data
);

    exc_state_e  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;

    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        redir_q, redir_d;
    logic [31:0] rpc_q, rpc_d;
    logic        wr_q, wr_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic        int_ok;

`ifdef EXC_INT_MASK_EN
    logic ie_q, ie_d;
    assign int_ok = int_req & ie_q;
`else
    assign int_ok = int_req;
`endif

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        code_d  = code_q;
`ifdef EXC_INT_MASK_EN
        ie_d    = ie_q;
`endif
        ack_d   = 1'b0;
        busy_d  = 1'b1;
        redir_d = 1'b0;
        rpc_d   = '0;
        wr_d    = 1'b0;
        wreg_d  = '0;
        wdata_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (exc_req || int_ok) begin
                    // Exception wins over interrupt; both capture the PC.
                    epc_d   = exc_pc;
                    code_d  = exc_req ? exc_code : INT_CODE;
                    state_d = S_W_EPC;
                    ack_d   = 1'b1;
                    wr_d    = 1'b1;
                    wreg_d  = CP0_EPC;
                    wdata_d = exc_pc;
                end else if (eret) begin
                    state_d = S_E_STAT;
                    ack_d   = 1'b1;
                    wr_d    = 1'b1;
                    wreg_d  = CP0_STATUS;
                    wdata_d = status_word(1'b0, 1'b1);
`ifdef EXC_INT_MASK_EN
                    ie_d    = 1'b1;
`endif
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_W_EPC: begin
                state_d = S_W_CAUSE;
                wr_d    = 1'b1;
                wreg_d  = CP0_CAUSE;
                wdata_d = cause_word(code_q);
            end
            S_W_CAUSE: begin
                state_d = S_W_STAT;
                wr_d    = 1'b1;
                wreg_d  = CP0_STATUS;
                wdata_d = status_word(1'b1, 1'b0);
`ifdef EXC_INT_MASK_EN
                ie_d    = 1'b0;
`endif
            end
            S_W_STAT: begin
                state_d = S_REDIR;
                redir_d = 1'b1;
                rpc_d   = HANDLER_ADDR;
            end
            S_E_STAT: begin
                state_d = S_REDIR;
                redir_d = 1'b1;
                rpc_d   = epc_q;
            end
            S_REDIR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            code_q  <= '0;
`ifdef EXC_INT_MASK_EN
            ie_q    <= 1'b1;
`endif
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            redir_q <= 1'b0;
            rpc_q   <= '0;
            wr_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
`ifdef EXC_INT_MASK_EN
            ie_q    <= ie_d;
`endif
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            redir_q <= redir_d;
            rpc_q   <= rpc_d;
            wr_q    <= wr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign exc_ack     = ack_q;
    assign busy        = busy_q;
    assign redirect    = redir_q;
    assign redirect_pc = rpc_q;
    assign CP0Wr       = wr_q;
    assign W_Reg       = wreg_q;
    assign W_data      = wdata_q;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_seq_ctrl -- directed bench for exc_seq_ctrl.
// Inputs change and outputs are checked 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_exc_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        int_req = 1'b0;
    logic        eret = 1'b0;
    logic        exc_ack, busy, redirect, CP0Wr;
    logic [31:0] redirect_pc, W_data;
    logic [4:0]  W_Reg;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_base;

    exc_seq_ctrl #(.HANDLER_ADDR(32'h0000_0080), .INT_CODE(5'd0)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
        .int_req(int_req), .eret(eret),
        .exc_ack(exc_ack), .busy(busy),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .CP0Wr(CP0Wr), .W_Reg(W_Reg), .W_data(W_data)
    );

    always #5 CLK = ~CLK;

    // CP0 samples on negedge; count completed writes the same way.
    always @(negedge CLK) if (CP0Wr === 1'b1) wr_cnt++;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic wr, input logic [4:0] r,
                          input logic [31:0] d, input logic ack);
        chk({tag, ".CP0Wr"},   {31'b0, CP0Wr},   {31'b0, wr});
        chk({tag, ".W_Reg"},   {27'b0, W_Reg},   {27'b0, r});
        chk({tag, ".W_data"},  W_data,           d);
        chk({tag, ".exc_ack"}, {31'b0, exc_ack}, {31'b0, ack});
        chk({tag, ".busy"},    {31'b0, busy},    32'd1);
        chk({tag, ".redir"},   {31'b0, redirect}, 32'd0);
    endtask

    task automatic chk_redir(input string tag, input logic [31:0] pc);
        chk({tag, ".redirect"}, {31'b0, redirect}, 32'd1);
        chk({tag, ".rpc"},      redirect_pc,       pc);
        chk({tag, ".CP0Wr"},    {31'b0, CP0Wr},    32'd0);
        chk({tag, ".W_Reg"},    {27'b0, W_Reg},    32'd0);
        chk({tag, ".busy"},     {31'b0, busy},     32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},     {31'b0, busy},     32'd0);
        chk({tag, ".CP0Wr"},    {31'b0, CP0Wr},    32'd0);
        chk({tag, ".redirect"}, {31'b0, redirect}, 32'd0);
        chk({tag, ".exc_ack"},  {31'b0, exc_ack},  32'd0);
    endtask

    initial begin
        // ---- reset state
        #2;
        chk_idle("rst");
        chk("rst.rpc", redirect_pc, 32'h0);
        chk("rst.W_data", W_data, 32'h0);
        step(); step();
        RST_n = 1'b1;

        // ---- 1: exception entry
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_0100;
        step();
        chk_wr("t1.epc", 1'b1, 5'd14, 32'h100, 1'b1);
        exc_req = 1'b0;
        step();
        chk_wr("t1.cause", 1'b1, 5'd13, 32'h10, 1'b0);
        step();
        chk_wr("t1.stat", 1'b1, 5'd12, 32'h2, 1'b0);
        step();
        chk_redir("t1.redir", 32'h80);
        step();
        chk_idle("t1.idle");

        // ---- 2: ERET back to saved EPC
        eret = 1'b1;
        step();
        chk_wr("t2.stat", 1'b1, 5'd12, 32'h1, 1'b1);
        eret = 1'b0;
        step();
        chk_redir("t2.redir", 32'h100);
        step();
        chk_idle("t2.idle");

        // ---- 3: exc + int + eret together; exception wins
        exc_req = 1'b1; exc_code = 5'd9; exc_pc = 32'h0000_0200;
        int_req = 1'b1; eret = 1'b1;
        step();
        chk_wr("t3.epc", 1'b1, 5'd14, 32'h200, 1'b1);
        exc_req = 1'b0; eret = 1'b0; exc_pc = 32'h0000_0300;
        step();
        chk_wr("t3.cause", 1'b1, 5'd13, 32'h24, 1'b0);
        step();
        chk_wr("t3.stat", 1'b1, 5'd12, 32'h2, 1'b0);
        step();
        chk_redir("t3.redir", 32'h80);
        step();
        chk_idle("t3.idle");

`ifdef EXC_INT_MASK_EN
        // ---- 4: masked interrupt waits for ERET
        step();
        chk_idle("t4.mask1");
        step();
        chk_idle("t4.mask2");
        eret = 1'b1;
        step();
        chk_wr("t4.estat", 1'b1, 5'd12, 32'h1, 1'b1);
        eret = 1'b0;
        step();
        chk_redir("t4.eredir", 32'h200);
        step();
        chk_idle("t4.idle");
        step();
        chk_wr("t4.int.epc", 1'b1, 5'd14, 32'h300, 1'b1);
`else
        // ---- 4: unmasked interrupt taken back-to-back
        step();
        chk_wr("t4.int.epc", 1'b1, 5'd14, 32'h300, 1'b1);
`endif
        int_req = 1'b0;
        step();
        chk_wr("t4.int.cause", 1'b1, 5'd13, 32'h0, 1'b0);
        step();
        chk_wr("t4.int.stat", 1'b1, 5'd12, 32'h2, 1'b0);
        step();
        chk_redir("t4.int.redir", 32'h80);
        step();
        chk_idle("t4.int.idle");

        // ---- 5: reset during W_CAUSE
        exc_req = 1'b1; exc_code = 5'd3; exc_pc = 32'h0000_0400;
        step();
        chk_wr("t5.epc", 1'b1, 5'd14, 32'h400, 1'b1);
        exc_req = 1'b0;
        step();
        chk("t5.cause.wr", {31'b0, CP0Wr}, 32'd1);
        wr_base = wr_cnt;
        #1 RST_n = 1'b0;
        #1;
        chk_idle("t5.rst");
        step();
        RST_n = 1'b1;
        step(); step(); step(); step();
        chk_idle("t5.after");
        chk("t5.wrcnt", wr_cnt, wr_base);

        // ---- 6: interrupt pulse only while busy is ignored
        wr_base = wr_cnt;
        exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h0000_0500;
        step();
        chk_wr("t6.epc", 1'b1, 5'd14, 32'h500, 1'b1);
        exc_req = 1'b0; int_req = 1'b1;
        step();
        chk_wr("t6.cause", 1'b1, 5'd13, 32'h4, 1'b0);
        step();
        chk_wr("t6.stat", 1'b1, 5'd12, 32'h2, 1'b0);
        int_req = 1'b0;
        step();
        chk_redir("t6.redir", 32'h80);
        step();
        chk_idle("t6.idle1");
        step();
        chk_idle("t6.idle2");
        step();
        chk_idle("t6.idle3");
        chk("t6.wrcnt", wr_cnt, wr_base + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
